emblem_seq_ctrl: RTL and testbench
==================================

Name: emblem_seq_ctrl

Overview:
- Frame-synchronous sequencer for the emblem overlay.
- On request it runs a slide-in, hold, blink and fade-out sequence. It drives the vertical offset that the top level subtracts from pixel y before feeding the emblem generator.
- It also composites the generator's draw/rgb over the background with a brightness clamp.
- Sits between the emblem generator and the VGA output register.

Parameters:
- SLIDE_START, 64, initial vertical offset in lines (7-bit, max 127).
- SLIDE_STEP, 2, offset decrement per frame.
- HOLD_FRAMES, 120, frames held at full brightness.
- BLINK_PERIOD, 8, frames per blink phase.
- BLINK_TOGGLES, 6, number of visibility toggles (even, so visibility ends at 1).
- FADE_FRAMES, 4, frames per brightness step during fade.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame, issued during vertical blanking.
- start  in  1  one-cycle request to begin the sequence.
- stop  in  1  one-cycle request to abort into fade-out.
- draw_in  in  1  emblem generator draw flag for the current pixel.
- rgb_in  in  6  emblem generator colour, RRGGBB.
- bg_rgb  in  6  background colour for the current pixel.
- y_offset  out  7  vertical offset applied upstream to the emblem y input.
- draw_out  out  1  registered: overlay pixel is shown.
- rgb_out  out  6  registered composited colour.
- busy  out  1  state != IDLE.
- state  out  3  IDLE=0, SLIDE=1, HOLD=2, BLINK=3, FADE=4.

Behaviour:
- Reset values: state IDLE, y_offset 0, level 0, visible 0, all counters 0, start_pend/stop_pend 0, draw_out 0, rgb_out 0, busy 0.
- Request latching:
  - start sets start_pend and stop sets stop_pend on any cycle.
  - Both pending flags are consumed and cleared on the next frame_tick.
  - A request arriving on the same cycle as frame_tick is acted on at that tick.
- State, y_offset, level, visible and frame counters change only on frame_tick cycles, so there is no mid-frame tearing.
- Transitions on a frame_tick, evaluated in this order:
  - stop_pend in SLIDE/HOLD/BLINK: go to FADE. Keep the current level (3), y_offset frozen, visible=1, fade counter=0. stop_pend in FADE or IDLE is discarded.
  - IDLE with start_pend and no stop_pend: go to SLIDE with y_offset=SLIDE_START, level=3, visible=1. If start and stop are both pending in IDLE, stay in IDLE.
  - start_pend while busy is discarded.
  - SLIDE: y_offset = max(y_offset - SLIDE_STEP, 0), saturating. The tick on which the result is 0 moves to HOLD with frame counter=0.
  - HOLD: increment frame counter. When it reaches HOLD_FRAMES, go to BLINK with counter=0 and toggle count=0.
  - BLINK: increment counter. At BLINK_PERIOD, invert visible, clear the counter and increment the toggle count. The tick on which the toggle count reaches BLINK_TOGGLES moves to FADE with visible=1.
  - FADE: increment counter. At FADE_FRAMES, decrement level and clear the counter. The tick on which level becomes 0 moves to IDLE with y_offset=0 and visible=0.
- Compositing (1-cycle registered latency, every clock):
  - show = draw_in & visible & (level != 0).
  - draw_out <= show.
  - rgb_out <= show ? {min(R,level), min(G,level), min(B,level)} : bg_rgb. Each channel is 2 bits, compared unsigned.
- Widths: counters sized to hold their parameter value; y_offset subtraction is done in 8 bits before saturation.
- Reset mid-sequence: all registers return to reset values immediately (asynchronously). Pending requests are lost.
- Nominal sequence length: ceil(64/2)=32 + 120 + 48 + 12 frames = 212 frame ticks to return to IDLE.

Test Plan:
- Reset then idle: 5 frame_ticks with no start → state 0, busy 0, draw_out 0, rgb_out = bg_rgb delayed by 1 cycle.
- Start pulse mid-frame: state stays 0 until the next frame_tick, then becomes 1 with y_offset 64. After 31 more ticks y_offset=2; the next tick gives y_offset 0 and state 2.
- Full run: after a single start, state returns to 0 exactly 212 ticks after the start is consumed. Visible is 0 during BLINK frames 8–15, 24–31 and 40–47. Level steps 3→2→1→0 every 4 ticks in FADE.
- Brightness clamp: in FADE at level 1 with draw_in=1 and rgb_in=6'b110110 → rgb_out=6'b010101 one cycle later. At level 0 → rgb_out=bg_rgb and draw_out=0.
- Simultaneous requests: start and stop in the same IDLE frame → stays IDLE. Stop during HOLD → FADE at the next tick with level 3, then IDLE 12 ticks later. Start during BLINK → ignored.
- Async reset asserted mid-SLIDE, between clock edges → all outputs 0 immediately. After release, no activity until a new start.

Source files
------------

// File: rtl/emblem_seq_ctrl.sv
`default_nettype none
// ============================================================================
// emblem_seq_ctrl : frame-synchronous slide/hold/blink/fade sequencer for the
//                   emblem overlay, plus brightness-clamped compositing.
// Revision 1.0
// ============================================================================
module emblem_seq_ctrl #(
    parameter int SLIDE_START   = 64,
    parameter int SLIDE_STEP    = 2,
    parameter int HOLD_FRAMES   = 120,
    parameter int BLINK_PERIOD  = 8,
    parameter int BLINK_TOGGLES = 6,
    parameter int FADE_FRAMES   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       stop,
    input  logic       draw_in,
    input  logic [5:0] rgb_in,
    input  logic [5:0] bg_rgb,
    output logic [6:0] y_offset,
    output logic       draw_out,
    output logic [5:0] rgb_out,
    output logic       busy,
    output logic [2:0] state
);

    localparam int CNT_MAX_HB = (HOLD_FRAMES > BLINK_PERIOD) ? HOLD_FRAMES : BLINK_PERIOD;
    localparam int CNT_MAX    = (CNT_MAX_HB > FADE_FRAMES) ? CNT_MAX_HB : FADE_FRAMES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int TOG_W      = $clog2(BLINK_TOGGLES + 1);

    localparam logic [6:0]       SLIDE_INIT = 7'(SLIDE_START);
    localparam logic [7:0]       STEP8      = 8'(SLIDE_STEP);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_FRAMES);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_PERIOD);
    localparam logic [CNT_W-1:0] FADE_LAST  = CNT_W'(FADE_FRAMES);
    localparam logic [TOG_W-1:0] TOG_LAST   = TOG_W'(BLINK_TOGGLES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SLIDE = 3'd1,
        ST_HOLD  = 3'd2,
        ST_BLINK = 3'd3,
        ST_FADE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       y_offset_q, y_offset_d;
    logic [1:0]       level_q, level_d;
    logic             visible_q, visible_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TOG_W-1:0] tog_q, tog_d;
    logic             start_pend_q, start_pend_d;
    logic             stop_pend_q, stop_pend_d;
    logic             draw_out_q, draw_out_d;
    logic [5:0]       rgb_out_q, rgb_out_d;

    logic             start_req;
    logic             stop_req;
    logic [7:0]       y_sub;
    logic [CNT_W-1:0] cnt_inc;
    logic [TOG_W-1:0] tog_inc;
    logic             show;

    function automatic logic [1:0] clamp2(input logic [1:0] c, input logic [1:0] l);
        return (c < l) ? c : l;
    endfunction

    // A request on the tick cycle itself is folded in so it is acted on immediately.
    assign start_req = start_pend_q | start;
    assign stop_req  = stop_pend_q | stop;
    assign y_sub     = {1'b0, y_offset_q} - STEP8;
    assign cnt_inc   = cnt_q + 1'b1;
    assign tog_inc   = tog_q + 1'b1;
    assign show      = draw_in & visible_q & (level_q != 2'd0);

    always_comb begin
        state_d      = state_q;
        y_offset_d   = y_offset_q;
        level_d      = level_q;
        visible_d    = visible_q;
        cnt_d        = cnt_q;
        tog_d        = tog_q;
        start_pend_d = frame_tick ? 1'b0 : start_req;
        stop_pend_d  = frame_tick ? 1'b0 : stop_req;

        if (frame_tick) begin
            if (stop_req && (state_q == ST_SLIDE || state_q == ST_HOLD || state_q == ST_BLINK)) begin
                state_d   = ST_FADE;
                visible_d = 1'b1;
                cnt_d     = '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start_req && !stop_req) begin
                            state_d    = ST_SLIDE;
                            y_offset_d = SLIDE_INIT;
                            level_d    = 2'd3;
                            visible_d  = 1'b1;
                            cnt_d      = '0;
                            tog_d      = '0;
                        end
                    end
                    ST_SLIDE: begin
                        if (y_sub[7] || y_sub == 8'd0) begin
                            y_offset_d = '0;
                            state_d    = ST_HOLD;
                            cnt_d      = '0;
                        end else begin
                            y_offset_d = y_sub[6:0];
                        end
                    end
                    ST_HOLD: begin
                        if (cnt_inc == HOLD_LAST) begin
                            state_d = ST_BLINK;
                            cnt_d   = '0;
                            tog_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    ST_BLINK: begin
                        if (cnt_inc == BLINK_LAST) begin
                            cnt_d     = '0;
                            visible_d = ~visible_q;
                            tog_d     = tog_inc;
                            if (tog_inc == TOG_LAST) begin
                                state_d   = ST_FADE;
                                visible_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    ST_FADE: begin
                        if (cnt_inc == FADE_LAST) begin
                            cnt_d   = '0;
                            level_d = level_q - 2'd1;
                            if (level_q == 2'd1) begin
                                state_d    = ST_IDLE;
                                y_offset_d = '0;
                                visible_d  = 1'b0;
                            end
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        draw_out_d = show;
        rgb_out_d  = show ? {clamp2(rgb_in[5:4], level_q),
                             clamp2(rgb_in[3:2], level_q),
                             clamp2(rgb_in[1:0], level_q)} : bg_rgb;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            y_offset_q   <= '0;
            level_q      <= '0;
            visible_q    <= 1'b0;
            cnt_q        <= '0;
            tog_q        <= '0;
            start_pend_q <= 1'b0;
            stop_pend_q  <= 1'b0;
            draw_out_q   <= 1'b0;
            rgb_out_q    <= '0;
        end else begin
            state_q      <= state_d;
            y_offset_q   <= y_offset_d;
            level_q      <= level_d;
            visible_q    <= visible_d;
            cnt_q        <= cnt_d;
            tog_q        <= tog_d;
            start_pend_q <= start_pend_d;
            stop_pend_q  <= stop_pend_d;
            draw_out_q   <= draw_out_d;
            rgb_out_q    <= rgb_out_d;
        end
    end

    assign y_offset = y_offset_q;
    assign draw_out = draw_out_q;
    assign rgb_out  = rgb_out_q;
    assign state    = state_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_emblem_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_emblem_seq_ctrl : scoreboard bench for the emblem overlay sequencer.
// Revision 1.0
// ============================================================================
module tb_emblem_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       draw_in = 1'b0;
    logic [5:0] rgb_in = '0;
    logic [5:0] bg_rgb = '0;
    logic [6:0] y_offset;
    logic       draw_out;
    logic [5:0] rgb_out;
    logic       busy;
    logic [2:0] state;

    emblem_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start      (start),
        .stop       (stop),
        .draw_in    (draw_in),
        .rgb_in     (rgb_in),
        .bg_rgb     (bg_rgb),
        .y_offset   (y_offset),
        .draw_out   (draw_out),
        .rgb_out    (rgb_out),
        .busy       (busy),
        .state      (state)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [6:0] sb_q[$];

    // Reference model, advanced once per frame_tick from elapsed-tick counts.
    logic [2:0] m_state;
    logic [6:0] m_y;
    logic [1:0] m_level;
    logic       m_vis;
    int         m_n;
    int         m_f;
    logic       m_sp;
    logic       m_tp;
    int         n_ticks = 0;
    bit         fixed_px = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_state = 3'd0; m_y = '0; m_level = '0; m_vis = 1'b0;
        m_n = 0; m_f = 0; m_sp = 1'b0; m_tp = 1'b0;
    endtask

    task automatic model_tick(input logic sp, input logic tp);
        if (tp && (m_state == 3'd1 || m_state == 3'd2 || m_state == 3'd3)) begin
            m_state = 3'd4; m_f = 0; m_vis = 1'b1;
        end else begin
            case (m_state)
                3'd0: if (sp && !tp) begin
                    m_state = 3'd1; m_n = 0; m_y = 7'd64; m_level = 2'd3; m_vis = 1'b1;
                end
                3'd4: begin
                    m_f++;
                    m_level = 2'(3 - m_f / 4);
                    if (m_f == 12) begin
                        m_state = 3'd0; m_y = '0; m_vis = 1'b0; m_level = '0;
                    end
                end
                default: begin
                    m_n++;
                    if (m_n < 32) m_y = 7'(64 - 2 * m_n);
                    else if (m_n < 152) begin m_state = 3'd2; m_y = '0; end
                    else if (m_n < 200) begin m_state = 3'd3; m_vis = (((m_n - 152) / 8) % 2) == 0; end
                    else begin m_state = 3'd4; m_f = 0; m_vis = 1'b1; end
                end
            endcase
        end
    endtask

    function automatic logic [6:0] exp_px(input logic d, input logic [5:0] c,
                                          input logic [5:0] bg, input logic v, input logic [1:0] l);
        logic       show;
        logic [1:0] r, g, b;
        show = d && v && (l != 2'd0);
        r = (c[5:4] < l) ? c[5:4] : l;
        g = (c[3:2] < l) ? c[3:2] : l;
        b = (c[1:0] < l) ? c[1:0] : l;
        return show ? {1'b1, r, g, b} : {1'b0, bg};
    endfunction

    task automatic cycle(input logic tk, input logic st, input logic sp);
        logic [6:0] e;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("draw_out", {31'd0, draw_out}, {31'd0, e[6]});
            check_val("rgb_out", {26'd0, rgb_out}, {26'd0, e[5:0]});
        end
        check_val("state", {29'd0, state}, {29'd0, m_state});
        check_val("y_offset", {25'd0, y_offset}, {25'd0, m_y});
        check_val("busy", {31'd0, busy}, {31'd0, m_state != 3'd0});
        frame_tick = tk; start = st; stop = sp;
        if (fixed_px) begin
            draw_in = 1'b1; rgb_in = 6'b110110;
        end else begin
            draw_in = 1'($urandom_range(0, 1)); rgb_in = 6'($urandom);
        end
        bg_rgb = 6'($urandom);
        sb_q.push_back(exp_px(draw_in, rgb_in, bg_rgb, m_vis, m_level));
        if (tk) begin
            n_ticks++;
            model_tick(m_sp | st, m_tp | sp);
            m_sp = 1'b0; m_tp = 1'b0;
        end else begin
            m_sp = m_sp | st; m_tp = m_tp | sp;
        end
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            cycle(1'b0, 1'b0, 1'b0);
            cycle(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         t0;
        int         k;
        logic [5:0] saved_bg;
        model_reset();
        #1;
        check_val("rst_state", {29'd0, state}, 32'd0);
        check_val("rst_y", {25'd0, y_offset}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_draw", {31'd0, draw_out}, 32'd0);
        check_val("rst_rgb", {26'd0, rgb_out}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        frames(5);

        // Start pulse mid-frame is held until the next tick.
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        settle();
        check_val("pend_idle", {29'd0, state}, 32'd0);
        cycle(1'b1, 1'b0, 1'b0);
        t0 = n_ticks;
        settle();
        check_val("slide_state", {29'd0, state}, 32'd1);
        check_val("slide_y64", {25'd0, y_offset}, 32'd64);
        frames(31);
        settle();
        check_val("slide_y2", {25'd0, y_offset}, 32'd2);
        frames(1);
        settle();
        check_val("hold_y0", {25'd0, y_offset}, 32'd0);
        check_val("hold_state", {29'd0, state}, 32'd2);

        k = 0;
        while (!(m_state == 3'd4 && m_level == 2'd1) && k < 300) begin
            frames(1);
            k++;
        end
        if (k >= 300) check_val("tmo_level1", 32'd1, 32'd0);
        fixed_px = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        settle();
        check_val("clamp_l1_rgb", {26'd0, rgb_out}, {26'd0, 6'b010101});
        check_val("clamp_l1_draw", {31'd0, draw_out}, 32'd1);
        fixed_px = 1'b0;

        k = 0;
        while (k < 100) begin
            frames(1);
            settle();
            k++;
            if (state == 3'd0) break;
        end
        check_val("seq_len", n_ticks - t0, 32'd212);

        fixed_px = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        saved_bg = bg_rgb;
        settle();
        check_val("l0_draw", {31'd0, draw_out}, 32'd0);
        check_val("l0_rgb", {26'd0, rgb_out}, {26'd0, saved_bg});
        fixed_px = 1'b0;

        // Start and stop together in IDLE.
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        settle();
        check_val("both_idle", {29'd0, state}, 32'd0);

        // Stop during HOLD.
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        frames(40);
        settle();
        check_val("in_hold", {29'd0, state}, 32'd2);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        settle();
        check_val("stop_fade", {29'd0, state}, 32'd4);
        frames(11);
        settle();
        check_val("stop_fade_11", {29'd0, state}, 32'd4);
        frames(1);
        settle();
        check_val("stop_idle_12", {29'd0, state}, 32'd0);

        // Start during BLINK is ignored.
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        frames(160);
        settle();
        check_val("in_blink", {29'd0, state}, 32'd3);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        frames(3);
        settle();
        check_val("blink_ign_start", {29'd0, state}, 32'd3);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        frames(12);
        settle();
        check_val("blink_abort_idle", {29'd0, state}, 32'd0);

        // Asynchronous reset between edges in SLIDE.
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        frames(5);
        cycle(1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_val("arst_state", {29'd0, state}, 32'd0);
        check_val("arst_y", {25'd0, y_offset}, 32'd0);
        check_val("arst_busy", {31'd0, busy}, 32'd0);
        check_val("arst_draw", {31'd0, draw_out}, 32'd0);
        check_val("arst_rgb", {26'd0, rgb_out}, 32'd0);
        model_reset();
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        frames(5);
        settle();
        check_val("post_rst_idle", {29'd0, state}, 32'd0);
        check_val("post_rst_y", {25'd0, y_offset}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
